uart_tx_sequencer: RTL

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/uart_tx_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_sequencer.sv
// Sends a fixed four-byte message to a UART transmitter on a start pulse,
// handshaking each byte against Tx_BUSY and flagging a missing busy acknowledge.
module uart_tx_sequencer #(
    parameter logic [7:0] MSG0        = 8'hAA,
    parameter logic [7:0] MSG1        = 8'h55,
    parameter logic [7:0] MSG2        = 8'hCC,
    parameter logic [7:0] MSG3        = 8'h89,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       Tx_BUSY,
    output logic [7:0] Tx_DATA,
    output logic       Tx_WR,
    output logic [1:0] byte_idx,
    output logic       seq_busy,
    output logic       seq_done,
    output logic       tx_error
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_HI,
        WAIT_LO,
        DONE
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       wr_q, wr_d;
    logic [1:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    function automatic logic [7:0] msg_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return MSG0;
            2'd1:    return MSG1;
            2'd2:    return MSG2;
            default: return MSG3;
        endcase
    endfunction

    // Outputs are computed alongside the next state so every output is a flop.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        wr_d    = 1'b0;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                idx_d  = 2'd0;
                busy_d = 1'b0;
                cnt_d  = 8'd0;
                if (start && !Tx_BUSY) begin
                    state_d = WRITE;
                    wr_d    = 1'b1;
                    data_d  = msg_byte(2'd0);
                    busy_d  = 1'b1;
                end
            end

            WRITE: begin
                state_d = WAIT_HI;
                cnt_d   = 8'd0;
            end

            // Busy acknowledge wins over a timeout landing on the same edge.
            WAIT_HI: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = 2'd0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            WAIT_LO: begin
                if (!Tx_BUSY) begin
                    if (idx_q != 2'd3) begin
                        state_d = WRITE;
                        idx_d   = idx_q + 2'd1;
                        wr_d    = 1'b1;
                        data_d  = msg_byte(idx_q + 2'd1);
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 2'd0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                idx_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            data_q  <= 8'h00;
            wr_q    <= 1'b0;
            idx_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Tx_DATA  = data_q;
    assign Tx_WR    = wr_q;
    assign byte_idx = idx_q;
    assign seq_busy = busy_q;
    assign seq_done = done_q;
    assign tx_error = err_q;

endmodule
